// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: oversampled start detection, LSB-first data capture, stop check.
// Optional `define UART_RX_MAJORITY_EN: 2-of-3 vote over the last three ticks for every bit decision.
module uart_rx_8n1 #(
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rx,
    output logic [7:0] rxbyte,
    output logic       rxdone,
    output logic       rxerr,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAITHI
    } state_e;

    localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(OVERSAMPLE - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       rxbyte_q, rxbyte_d;
    logic             rxdone_q, rxdone_d;
    logic             rxerr_q, rxerr_d;
    logic [1:0]       sync_q;
    logic             rx_s;
    logic             bit_val;

    // Two-flop synchronizer runs every clk; reset to the idle line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    // Samples from the two previous ticks; the live rx_s is the third vote.
    logic [1:0] hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else if (en) begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            rxbyte_q <= '0;
            rxdone_q <= 1'b0;
            rxerr_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            rxbyte_q <= rxbyte_d;
            rxdone_q <= rxdone_d;
            rxerr_q  <= rxerr_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path infers a latch.
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        rxbyte_d = rxbyte_q;
        rxdone_d = 1'b0;
        rxerr_d  = 1'b0;

        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == HALF_TC) begin
                        tick_d = '0;
                        if (!bit_val) begin
                            state_d = DATA;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == FULL_TC) begin
                        shreg_d = {bit_val, shreg_q[7:1]};
                        bit_d   = bit_q + 4'd1;
                        tick_d  = '0;
                        if (bit_q == 4'd7) begin
                            state_d = STOP;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                STOP: begin
                    // Decision is mid-stop-bit, so a following start edge is not missed.
                    if (tick_q == FULL_TC) begin
                        tick_d = '0;
                        if (bit_val) begin
                            rxbyte_d = shreg_q;
                            rxdone_d = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            rxerr_d = 1'b1;
                            state_d = WAITHI;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                WAITHI: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tick_d  = '0;
                end
            endcase
        end
    end

    assign rxbyte = rxbyte_q;
    assign rxdone = rxdone_q;
    assign rxerr  = rxerr_q;
    assign busy   = (state_q != IDLE);

endmodule
